// File: rtl/count_arb.sv
// Two-requester round-robin arbiter that owns a 4-bit modulo up/down counter.
// A granted command runs to completion and returns the final count with a done pulse.
module count_arb #(
    parameter int unsigned MOD_MAX = 11,
    parameter int unsigned STEP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [3:0]        data0,
    input  logic [3:0]        data1,
    input  logic [STEP_W-1:0] steps0,
    input  logic [STEP_W-1:0] steps1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              owner,
    output logic [3:0]        count_o,
    output logic [1:0]        done,
    output logic [3:0]        result
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [1:0] CmdNop  = 2'b00;
    localparam logic [1:0] CmdLoad = 2'b01;
    localparam logic [1:0] CmdUp   = 2'b10;
    localparam logic [1:0] CmdDown = 2'b11;
    localparam logic [3:0] ModMax  = 4'(MOD_MAX);

    state_e            state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic [3:0]        result_q, result_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [3:0]        data_q, data_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              sel;
    logic [3:0]        count_up, count_dn;

    // Out-of-range values (above ModMax) normalise on their first step.
    assign count_up = (count_q >= ModMax) ? 4'd0 : count_q + 4'd1;
    assign count_dn = (count_q == 4'd0 || count_q > ModMax) ? ModMax : count_q - 4'd1;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        busy_d   = busy_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        result_d = result_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        rem_d    = rem_q;
        sel      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    // Under contention the requester not served last wins.
                    sel     = (req == 2'b11) ? ~ptr_q : req[1];
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    cmd_d   = sel ? cmd1 : cmd0;
                    data_d  = sel ? data1 : data0;
                    rem_d   = sel ? steps1 : steps0;
                    owner_d = sel;
                    ptr_d   = sel;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                unique case (cmd_q)
                    CmdNop: state_d = StDone;
                    CmdLoad: begin
                        count_d = data_q;
                        state_d = StDone;
                    end
                    CmdUp, CmdDown: begin
                        if (rem_q == '0) begin
                            state_d = StDone;
                        end else begin
                            count_d = (cmd_q == CmdUp) ? count_up : count_dn;
                            rem_d   = rem_q - 1'b1;
                            // The final step leaves RUN directly so done follows it by one edge.
                            if (rem_q == STEP_W'(1)) state_d = StDone;
                        end
                    end
                    default: state_d = StDone;
                endcase
            end
            StDone: begin
                done_d   = owner_q ? 2'b10 : 2'b01;
                result_d = count_q;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= 4'd0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            busy_q   <= 1'b0;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b1;
            result_q <= 4'd0;
            cmd_q    <= CmdNop;
            data_q   <= 4'd0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign count_o = count_q;
    assign result  = result_q;

endmodule
